// File: rtl/ddr_pkg.sv
// Shared definitions for the note sequencer: FSM states and lane bit positions.
package ddr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_PAUSED,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

    localparam int LANE_W = 4;
    localparam int LANE_U = 3;
    localparam int LANE_D = 2;
    localparam int LANE_L = 1;
    localparam int LANE_R = 0;

    // Builds a {U,D,L,R} lane mask from individual lane flags.
    function automatic logic [LANE_W-1:0] lane_mask(input logic u, input logic d,
                                                    input logic l, input logic r);
        logic [LANE_W-1:0] m;
        m         = '0;
        m[LANE_U] = u;
        m[LANE_D] = d;
        m[LANE_L] = l;
        m[LANE_R] = r;
        return m;
    endfunction

endpackage

// File: rtl/spawn_fifo.sv
// Small FIFO of lane masks waiting to be spawned. DEPTH must be a power of 2 (>=2).
// A push on a full FIFO is accepted when a pop happens on the same cycle.
module spawn_fifo
    import ddr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [LANE_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [LANE_W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [LANE_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_q, wr_d;
    logic [AW:0]       rd_q, rd_d;
    logic              do_push;
    logic              do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_q[AW-1:0]];

    // Next pointer values; clear empties the FIFO regardless of push/pop.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (clr) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/note_sequencer.sv
// Steps through a fixed lane-mask song one beat every BEAT_CYCLES clocks,
// buffers non-rest beats in a spawn FIFO and offers them to the graphics
// block with a valid/ready handshake, at most one per video frame.
module note_sequencer
    import ddr_pkg::*;
#(
    parameter int                    BEAT_CYCLES = 25000000,
    parameter int                    PAT_LEN     = 32,
    parameter logic [PAT_LEN*4-1:0]  PATTERN     = 128'h1284_0812_4018_2048_1020_4081_0240_8421,
    parameter int                    FIFO_DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       pause,
    input  logic                       frame_start,
    input  logic                       spawn_ready,
    output logic                       spawn_valid,
    output logic [LANE_W-1:0]          spawn_lanes,
    output logic [$clog2(PAT_LEN)-1:0] beat_idx,
    output logic                       busy,
    output logic                       done,
    output logic [7:0]                 drop_cnt
);

    localparam int                CNT_W    = $clog2(BEAT_CYCLES);
    localparam int                IDX_W    = $clog2(PAT_LEN);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BEAT_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(PAT_LEN - 1);

    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;
    logic [LANE_W-1:0] lanes_q, lanes_d;
    logic [7:0]        drop_q, drop_d;

    logic              start_ok;
    logic              running;
    logic              beat_fire;
    logic              last_beat;
    logic [LANE_W-1:0] beat_mask;
    logic              accept;
    logic              spawn_hold;
    logic              launch;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LANE_W-1:0] fifo_head;
    logic              drop;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Song timing only advances while playing and not held by pause; leaving
    // PAUSED counts on the same cycle pause drops so a pause of N cycles
    // delays the song by exactly N cycles.
    assign start_ok   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign running    = ((state_q == ST_PLAY) || (state_q == ST_PAUSED)) && !pause;
    assign beat_fire  = running && (cnt_q == CNT_LAST);
    assign last_beat  = beat_fire && (idx_q == IDX_LAST);
    assign beat_mask  = PATTERN[{idx_q, 2'b00} +: LANE_W];
    assign accept     = valid_q && spawn_ready;
    assign fifo_push  = beat_fire && (|beat_mask) && (!fifo_full || accept);
    assign drop       = beat_fire && (|beat_mask) && fifo_full && !accept;
    // No new offer may start while the song is frozen (or about to freeze).
    assign spawn_hold = (state_q == ST_PAUSED) || ((state_q == ST_PLAY) && pause);
    assign launch     = !valid_q && frame_start && !fifo_empty && !spawn_hold;

    spawn_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .push  (fifo_push),
        .pop   (accept),
        .din   (beat_mask),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // FSM next-state decision.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_PLAY;
            ST_PLAY: begin
                if (last_beat)  state_d = ST_DRAIN;
                else if (pause) state_d = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (last_beat)   state_d = ST_DRAIN;
                else if (!pause) state_d = ST_PLAY;
            end
            ST_DRAIN: if (fifo_empty && !valid_q) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Beat counter, beat index, spawn offer and drop counter updates.
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        lanes_d = lanes_q;
        drop_d  = drop_q;
        if (running) begin
            cnt_d = beat_fire ? '0 : cnt_q + 1'b1;
            if (beat_fire) idx_d = idx_q + 1'b1;
        end
        if (drop) drop_d = sat_inc8(drop_q);
        if (accept) begin
            valid_d = 1'b0;
            lanes_d = '0;
        end else if (launch) begin
            valid_d = 1'b1;
            lanes_d = fifo_head;
        end
        if (start_ok) begin
            cnt_d   = '0;
            idx_d   = '0;
            drop_d  = '0;
            valid_d = 1'b0;
            lanes_d = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            lanes_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            lanes_q <= lanes_d;
            drop_q  <= drop_d;
        end
    end

    assign spawn_valid = valid_q;
    assign spawn_lanes = lanes_q;
    assign beat_idx    = idx_q;
    assign drop_cnt    = drop_q;
    assign busy        = (state_q == ST_PLAY) || (state_q == ST_PAUSED) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);

endmodule
